multimode_johnson_counter: RTL and testbench

- Parametrised successor to the team's pipelined Johnson counter.
- Core shift-register counter with runtime-selectable twisted-ring (Johnson) or one-hot ring mode, and runtime direction, enable and parallel load.
- Illegal states are detected and self-corrected.
- Output passes through a STAGES-deep register pipeline with valid, wrap and error flags kept aligned to q. Used as a low-glitch phase/sequence generator in clocking and sequencing logic.

---
 rtl/multimode_johnson_counter.sv | 137 +++++++++++++
 tb/tb_multimode_johnson_counter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multimode_johnson_counter.sv
// multimode_johnson_counter
// Shift-register sequence generator that runs either as a twisted-ring
// (Johnson) counter or as a one-hot ring, with runtime direction, enable
// and parallel load. Illegal core states are replaced by the seed of the
// current mode. The core value travels through a STAGES-deep register
// pipeline together with its valid, wrap and error flags so that all four
// outputs always describe the same core value.

module multimode_johnson_counter #(
  parameter int N      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         mode,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic         q_valid,
  output logic         wrap,
  output logic         err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CntOne = CW'(1);
  localparam logic [N-1:0] JohnsonSeed = '0;
  localparam logic [N-1:0] RingSeed = {{(N-1){1'b0}}, 1'b1};
  localparam int PW = N + 3;

  logic [N-1:0]  r_s;
  logic          r_modeQ;
  logic          r_wrapC;
  logic          r_errC;
  logic          r_sValid;
  logic [PW-1:0] r_pipe [STAGES];

  logic [N-1:0]  w_seedMode;
  logic [N-1:0]  w_seedModeQ;
  logic [N-1:0]  w_step;
  logic [CW-1:0] w_trans;
  logic [CW-1:0] w_ones;
  logic          w_legal;
  logic [N-1:0]  w_nextS;
  logic          w_nextModeQ;
  logic          w_nextWrap;
  logic          w_nextErr;

  // Seed values for the requested mode and for the mode the core is running in
  always_comb begin
    w_seedMode  = mode ? RingSeed : JohnsonSeed;
    w_seedModeQ = r_modeQ ? RingSeed : JohnsonSeed;
  end

  // Legality of the current core value: Johnson allows one boundary between
  // runs of equal bits, ring allows exactly one set bit
  always_comb begin
    w_trans = '0;
    w_ones  = '0;
    for (int i = 0; i < N - 1; i++) begin
      w_trans = w_trans + {{(CW-1){1'b0}}, r_s[i] ^ r_s[i+1]};
    end
    for (int i = 0; i < N; i++) begin
      w_ones = w_ones + {{(CW-1){1'b0}}, r_s[i]};
    end
    w_legal = r_modeQ ? (w_ones == CntOne) : (w_trans <= CntOne);
  end

  // One shift step in the running mode; Johnson feeds back the inverted end bit
  always_comb begin
    w_step = r_s;
    if (!r_modeQ) begin
      w_step = dir ? {r_s[N-2:0], ~r_s[N-1]} : {~r_s[0], r_s[N-1:1]};
    end else begin
      w_step = dir ? {r_s[N-2:0], r_s[N-1]} : {r_s[0], r_s[N-1:1]};
    end
  end

  // Core priority: load, then mode change, then correction, then step, else hold
  always_comb begin
    w_nextS     = r_s;
    w_nextModeQ = r_modeQ;
    w_nextWrap  = 1'b0;
    w_nextErr   = 1'b0;
    if (load) begin
      w_nextS     = load_val;
      w_nextModeQ = mode;
    end else if (mode != r_modeQ) begin
      w_nextS     = w_seedMode;
      w_nextModeQ = mode;
    end else if (en && !w_legal) begin
      w_nextS   = w_seedModeQ;
      w_nextErr = 1'b1;
    end else if (en) begin
      w_nextS    = w_step;
      w_nextWrap = (w_step == w_seedModeQ);
    end
  end

  // Core register; r_sValid marks that r_s holds a value registered after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s      <= '0;
      r_modeQ  <= 1'b0;
      r_wrapC  <= 1'b0;
      r_errC   <= 1'b0;
      r_sValid <= 1'b0;
    end else begin
      r_s      <= w_nextS;
      r_modeQ  <= w_nextModeQ;
      r_wrapC  <= w_nextWrap;
      r_errC   <= w_nextErr;
      r_sValid <= 1'b1;
    end
  end

  // Free-running output pipeline carrying value and flags together
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < STAGES; j++) begin
        r_pipe[j] <= '0;
      end
    end else begin
      r_pipe[0] <= {r_s, r_wrapC, r_errC, r_sValid};
      for (int j = 1; j < STAGES; j++) begin
        r_pipe[j] <= r_pipe[j-1];
      end
    end
  end

  assign q       = r_pipe[STAGES-1][PW-1:3];
  assign wrap    = r_pipe[STAGES-1][2];
  assign err     = r_pipe[STAGES-1][1];
  assign q_valid = r_pipe[STAGES-1][0];

endmodule

// File: tb/tb_multimode_johnson_counter.sv
// tb_multimode_johnson_counter
// Directed scenarios plus a randomized run, each checked against a
// sequence-table reference model of the counter.

module tb_multimode_johnson_counter;

  localparam int N      = 4;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         dir = 1'b0;
  logic         mode = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] q;
  logic         q_valid;
  logic         wrap;
  logic         err;

  int assertCount = 0;
  int failCount = 0;

  typedef struct packed {
    logic [N-1:0] val;
    logic         w;
    logic         e;
  } entry_t;

  entry_t       pipe[$];
  logic [N-1:0] jSeq [2*N];
  logic [N-1:0] rSeq [N];
  logic [N-1:0] mS;
  logic         mModeQ;
  logic         mWrap;
  logic         mErr;
  int           edgeCnt = 0;
  logic [N-1:0] eQ;
  logic         eW;
  logic         eE;
  logic         eV;

  multimode_johnson_counter #(.N(N), .STAGES(STAGES)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .dir(dir),
    .mode(mode),
    .load(load),
    .load_val(load_val),
    .q(q),
    .q_valid(q_valid),
    .wrap(wrap),
    .err(err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Sequence tables: Johnson state k is a thermometer of k ones entering from
  // the top, then 2N-k ones draining at the bottom; ring state k is one bit
  // rotating down from the top. Index 0 is the seed, right steps add one.
  task automatic buildTables();
    for (int k = 0; k < 2 * N; k++) begin
      if (k <= N) jSeq[k] = N'(((1 << k) - 1) << (N - k));
      else        jSeq[k] = N'((1 << (2 * N - k)) - 1);
    end
    for (int k = 0; k < N; k++) rSeq[k] = N'(1 << ((N - k) % N));
  endtask

  function automatic logic [N-1:0] seedOf(input logic m);
    return m ? rSeq[0] : jSeq[0];
  endfunction

  function automatic int findIdx(input logic [N-1:0] v, input logic m);
    int len;
    len = m ? N : 2 * N;
    for (int k = 0; k < len; k++) begin
      if ((m ? rSeq[k] : jSeq[k]) == v) return k;
    end
    return -1;
  endfunction

  // Reference model for one rising edge, using the inputs the DUT sampled
  task automatic modelEdge();
    int idx;
    int len;
    logic nw;
    logic ne;
    entry_t head;
    if (reset) begin
      mS = '0; mModeQ = 1'b0; mWrap = 1'b0; mErr = 1'b0; edgeCnt = 0;
      pipe.delete();
      repeat (STAGES) pipe.push_back('0);
    end else begin
      pipe.push_back({mS, mWrap, mErr});
      void'(pipe.pop_front());
      edgeCnt++;
      nw = 1'b0;
      ne = 1'b0;
      if (load) begin
        mS = load_val; mModeQ = mode;
      end else if (mode != mModeQ) begin
        mS = seedOf(mode); mModeQ = mode;
      end else if (en) begin
        idx = findIdx(mS, mModeQ);
        len = mModeQ ? N : 2 * N;
        if (idx < 0) begin
          mS = seedOf(mModeQ); ne = 1'b1;
        end else begin
          idx = dir ? (idx + len - 1) % len : (idx + 1) % len;
          mS = mModeQ ? rSeq[idx] : jSeq[idx];
          nw = (idx == 0);
        end
      end
      mWrap = nw;
      mErr  = ne;
    end
    head = pipe[0];
    eQ = head.val; eW = head.w; eE = head.e;
    eV = (edgeCnt >= STAGES + 1);
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'($urandom_range(0, 1)); dir = 1'($urandom_range(0, 1));
    mode = 1'($urandom_range(0, 1)); load = 1'($urandom_range(0, 1));
    load_val = N'($urandom);
    reset = 1'b1;
    tick();
    assertCount++;
    if ({q, wrap, err, q_valid} !== 7'b0) begin
      failCount++;
      $display("[TB] FAIL reset_state: got q/w/e/v=%b want 0000000", {q, wrap, err, q_valid});
    end
    reset = 1'b0; en = 1'b1; dir = 1'b0; mode = 1'b0; load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      assertCount++;
      if (q_valid !== (k >= 3)) begin
        failCount++;
        $display("[TB] FAIL reset_valid edge %0d: got %b want %b", k, q_valid, k >= 3);
      end
      assertCount++;
      if ({q, wrap, err, q_valid} !== {eQ, eW, eE, eV}) begin
        failCount++;
        $display("[TB] FAIL model_reset edge %0d: got %b want %b", k, {q, wrap, err, q_valid}, {eQ, eW, eE, eV});
      end
    end
  endtask

  task automatic test_johnson_right();
    logic [N-1:0] jr [9];
    jr = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    doReset();
    en = 1'b1; dir = 1'b0; mode = 1'b0; load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k >= 2 && k <= 10) begin
        assertCount++;
        if (q !== jr[k-2]) begin
          failCount++;
          $display("[TB] FAIL johnson_right_q edge %0d: got %b want %b", k, q, jr[k-2]);
        end
      end
      assertCount++;
      if (wrap !== (k == 10)) begin
        failCount++;
        $display("[TB] FAIL johnson_right_wrap edge %0d: got %b want %b", k, wrap, k == 10);
      end
      assertCount++;
      if ({q, wrap, err, q_valid} !== {eQ, eW, eE, eV}) begin
        failCount++;
        $display("[TB] FAIL model_jright edge %0d: got %b want %b", k, {q, wrap, err, q_valid}, {eQ, eW, eE, eV});
      end
    end
  endtask

  task automatic test_johnson_left();
    logic [N-1:0] jl [9];
    jl = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    doReset();
    en = 1'b1; dir = 1'b1; mode = 1'b0; load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k >= 2) begin
        assertCount++;
        if ({q, wrap} !== {jl[k-2], k == 10}) begin
          failCount++;
          $display("[TB] FAIL johnson_left edge %0d: got q/w=%b want %b", k, {q, wrap}, {jl[k-2], k == 10});
        end
      end
      assertCount++;
      if ({q, wrap, err, q_valid} !== {eQ, eW, eE, eV}) begin
        failCount++;
        $display("[TB] FAIL model_jleft edge %0d: got %b want %b", k, {q, wrap, err, q_valid}, {eQ, eW, eE, eV});
      end
    end
    doReset();
    for (int k = 1; k <= 6; k++) begin
      dir = (k < 4);
      tick();
      if (k == 5 || k == 6) begin
        assertCount++;
        if ({q, err} !== {(k == 5) ? 4'b0111 : 4'b0011, 1'b0}) begin
          failCount++;
          $display("[TB] FAIL dir_flip edge %0d: got q/e=%b want %b", k, {q, err}, {(k == 5) ? 4'b0111 : 4'b0011, 1'b0});
        end
      end
      assertCount++;
      if ({q, wrap, err, q_valid} !== {eQ, eW, eE, eV}) begin
        failCount++;
        $display("[TB] FAIL model_dirflip edge %0d: got %b want %b", k, {q, wrap, err, q_valid}, {eQ, eW, eE, eV});
      end
    end
  endtask

  task automatic test_mode_switch();
    doReset();
    dir = 1'b0; load = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      en = (k != 3);
      mode = (k >= 3);
      tick();
      if (k == 5) begin
        assertCount++;
        if ({q, wrap, err} !== {4'b0001, 1'b0, 1'b0}) begin
          failCount++;
          $display("[TB] FAIL mode_switch_seed: got q/w/e=%b want 0001_0_0", {q, wrap, err});
        end
      end
      if (k == 9) begin
        assertCount++;
        if ({q, wrap} !== {4'b0001, 1'b1}) begin
          failCount++;
          $display("[TB] FAIL ring_wrap: got q/w=%b want 0001_1", {q, wrap});
        end
      end
      assertCount++;
      if ({q, wrap, err, q_valid} !== {eQ, eW, eE, eV}) begin
        failCount++;
        $display("[TB] FAIL model_mode edge %0d: got %b want %b", k, {q, wrap, err, q_valid}, {eQ, eW, eE, eV});
      end
    end
  endtask

  task automatic test_load_illegal();
    doReset();
    dir = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      load = (k == 1 || k == 5);
      load_val = (k == 1) ? 4'b0101 : 4'b0110;
      mode = (k >= 5);
      en = (k >= 2);
      tick();
      if (k == 3 || k == 4 || k == 8) begin
        assertCount++;
        if ({q, err} !== ((k == 3) ? 5'b0101_0 : (k == 4) ? 5'b0000_1 : 5'b0001_1)) begin
          failCount++;
          $display("[TB] FAIL load_correct edge %0d: got q/e=%b want %b", k, {q, err},
                   (k == 3) ? 5'b0101_0 : (k == 4) ? 5'b0000_1 : 5'b0001_1);
        end
      end
      assertCount++;
      if ({q, wrap, err, q_valid} !== {eQ, eW, eE, eV}) begin
        failCount++;
        $display("[TB] FAIL model_load edge %0d: got %b want %b", k, {q, wrap, err, q_valid}, {eQ, eW, eE, eV});
      end
    end
    load = 1'b0;
  endtask

  task automatic test_hold_load();
    doReset();
    dir = 1'b0; mode = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      en = (k <= 3);
      load = (k == 9);
      load_val = 4'b0011;
      tick();
      if (k >= 5) begin
        assertCount++;
        if ({q, wrap, err} !== {(k == 11) ? 4'b0011 : 4'b1110, 2'b00}) begin
          failCount++;
          $display("[TB] FAIL hold_load edge %0d: got q/w/e=%b want %b", k, {q, wrap, err},
                   {(k == 11) ? 4'b0011 : 4'b1110, 2'b00});
        end
      end
      assertCount++;
      if ({q, wrap, err, q_valid} !== {eQ, eW, eE, eV}) begin
        failCount++;
        $display("[TB] FAIL model_hold edge %0d: got %b want %b", k, {q, wrap, err, q_valid}, {eQ, eW, eE, eV});
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    doReset();
    dir = 1'b0; mode = 1'b0; load = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      en = (k <= 3) || (k >= 7);
      reset = (k == 6);
      tick();
      if (k == 6) begin
        assertCount++;
        if ({q, wrap, err, q_valid} !== 7'b0) begin
          failCount++;
          $display("[TB] FAIL reset_mid: got q/w/e/v=%b want 0000000", {q, wrap, err, q_valid});
        end
      end
      if (k == 8 || k == 9) begin
        assertCount++;
        if ({q, q_valid} !== ((k == 8) ? 5'b0000_0 : 5'b1000_1)) begin
          failCount++;
          $display("[TB] FAIL restart edge %0d: got q/v=%b want %b", k, {q, q_valid},
                   (k == 8) ? 5'b0000_0 : 5'b1000_1);
        end
      end
      assertCount++;
      if ({q, wrap, err, q_valid} !== {eQ, eW, eE, eV}) begin
        failCount++;
        $display("[TB] FAIL model_resetmid edge %0d: got %b want %b", k, {q, wrap, err, q_valid}, {eQ, eW, eE, eV});
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 249) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      load = ($urandom_range(0, 15) == 0);
      load_val = N'($urandom);
      tick();
      assertCount++;
      if ({q, wrap, err, q_valid} !== {eQ, eW, eE, eV}) begin
        failCount++;
        $display("[TB] FAIL model_random cycle %0d: got %b want %b", k, {q, wrap, err, q_valid}, {eQ, eW, eE, eV});
      end
    end
    reset = 1'b0; load = 1'b0;
  endtask

  initial begin
    buildTables();
    test_reset();
    test_johnson_right();
    test_johnson_left();
    test_mode_switch();
    test_load_illegal();
    test_hold_load();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
